// File: rtl/ysyx_040066_booth_wallace_mul_pipe.sv
// ysyx_040066_booth_wallace_mul_pipe: 3-stage radix-4 Booth / Wallace-tree multiplier for RV64M
module ysyx_040066_csa #(
   parameter int W = 128
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic [W-1:0] c,
   output logic [W-1:0] s,
   output logic [W-1:0] co
);
   assign s  = a ^ b ^ c;
   assign co = ((a & b) | (b & c) | (a & c)) << 1;
endmodule

module ysyx_040066_booth_wallace_mul_pipe #(
   parameter int XLEN   = 64,
   parameter int PP_NUM = (XLEN + 2) / 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] src1,
   input  logic [XLEN-1:0] src2,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result
);
   localparam int PW   = 2 * XLEN;
   localparam int ROWS = PP_NUM + 1;
   localparam logic [XLEN-1:0] W_MASK = XLEN'(64'hFFFF_FFFF);

   function automatic int rows_at(input int l);
      int n = ROWS;
      for (int k = 0; k < l; k++) n = n / 3 * 2 + n % 3;
      return n;
   endfunction

   function automatic int depth();
      int n = ROWS;
      int d = 0;
      while (n > 4) begin
         n = n / 3 * 2 + n % 3;
         d++;
      end
      return d;
   endfunction

   localparam int LV = depth();

   logic            s1_v, s2_v, adv1, adv2, adv3, accept, is_w, s3_w, s3_hi;
   logic [2:0]      s1_op, s2_op;
   logic [XLEN+1:0] a_ext, b_ext;
   logic [XLEN+2:0] bx;
   logic [PW-1:0]   a_sx, mag, f0_s, f0_c, f1_s, f1_c, prod;
   logic [2:0]      d;
   logic            one, two, neg;
   logic [XLEN-1:0] lo, res_nxt;
   logic [PW-1:0]   pp     [0:PP_NUM];
   logic [PW-1:0]   s1_pp  [0:PP_NUM];
   logic [PW-1:0]   s2_row [0:3];
   logic [PW-1:0]   tree   [0:LV][0:ROWS-1];

   assign adv3     = !out_valid || out_ready;
   assign adv2     = !s2_v || adv3;
   assign adv1     = !s1_v || adv2;
   assign in_ready = !flush && adv1;
   assign accept   = in_valid && in_ready;

   // Extend operands per op and build the Booth partial products; the last row collects the negation carry-ins
   always_comb begin
      is_w  = (XLEN == 64) && (op == 3'b100);
      a_ext = is_w ? {{(XLEN-30){src1[31]}}, src1[31:0]}
                   : {{2{(op == 3'b001 || op == 3'b010) && src1[XLEN-1]}}, src1};
      b_ext = is_w ? {{(XLEN-30){src2[31]}}, src2[31:0]}
                   : {{2{(op == 3'b001) && src2[XLEN-1]}}, src2};
      a_sx  = {{(XLEN-2){a_ext[XLEN+1]}}, a_ext};
      bx    = {b_ext, 1'b0};
      d     = '0;
      one   = 1'b0;
      two   = 1'b0;
      neg   = 1'b0;
      mag   = '0;
      pp    = '{default: '0};
      for (int i = 0; i < PP_NUM; i++) begin
         d   = bx[2*i +: 3];
         one = d[0] ^ d[1];
         two = (d == 3'b011) || (d == 3'b100);
         neg = d[2] && !(d[1] && d[0]);
         mag = one ? a_sx : two ? (a_sx << 1) : '0;
         pp[i] = (neg ? ~mag : mag) << (2 * i);
         pp[PP_NUM][2*i] = neg;
      end
   end

   for (genvar j = 0; j < ROWS; j++) begin : g_in
      assign tree[0][j] = s1_pp[j];
   end

   for (genvar l = 0; l < LV; l++) begin : g_lvl
      localparam int N = rows_at(l);
      localparam int G = N / 3;
      for (genvar j = 0; j < G; j++) begin : g_csa
         ysyx_040066_csa #(.W(PW)) u_csa (
            .a (tree[l][3*j]),
            .b (tree[l][3*j+1]),
            .c (tree[l][3*j+2]),
            .s (tree[l+1][2*j]),
            .co(tree[l+1][2*j+1])
         );
      end
      for (genvar j = 0; j < N % 3; j++) begin : g_pass
         assign tree[l+1][2*G+j] = tree[l][3*G+j];
      end
      for (genvar j = rows_at(l + 1); j < ROWS; j++) begin : g_zero
         assign tree[l+1][j] = '0;
      end
   end

   ysyx_040066_csa #(.W(PW)) u_f0 (
      .a (s2_row[0]),
      .b (s2_row[1]),
      .c (s2_row[2]),
      .s (f0_s),
      .co(f0_c)
   );

   ysyx_040066_csa #(.W(PW)) u_f1 (
      .a (f0_s),
      .b (f0_c),
      .c (s2_row[3]),
      .s (f1_s),
      .co(f1_c)
   );

   // Final carry-propagate add and per-op selection of the product bits
   always_comb begin
      prod    = f1_s + f1_c;
      lo      = prod[XLEN-1:0];
      s3_w    = (XLEN == 64) && (s2_op == 3'b100);
      s3_hi   = (s2_op == 3'b001) || (s2_op == 3'b010) || (s2_op == 3'b011);
      res_nxt = s3_hi ? prod[PW-1:XLEN] : s3_w ? (prod[31] ? (lo | ~W_MASK) : (lo & W_MASK)) : lo;
   end

   // Pipeline registers: each stage loads when it is empty or its successor moves; flush empties them all
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_v      <= 1'b0;
         s2_v      <= 1'b0;
         out_valid <= 1'b0;
         s1_op     <= '0;
         s2_op     <= '0;
         s1_pp     <= '{default: '0};
         s2_row    <= '{default: '0};
         result    <= '0;
      end else if (flush) begin
         s1_v      <= 1'b0;
         s2_v      <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         if (adv1) s1_v <= accept;
         if (accept) begin
            s1_op <= op;
            s1_pp <= pp;
         end
         if (adv2) s2_v <= s1_v;
         if (adv2 && s1_v) begin
            s2_op <= s1_op;
            for (int k = 0; k < 4; k++) s2_row[k] <= tree[LV][k];
         end
         if (adv3) out_valid <= s2_v;
         if (adv3 && s2_v) result <= res_nxt;
      end
   end
endmodule
